nios_qsys_onchip_mem_arbiter: RTL and testbench

Two-port Avalon-MM arbiter that shares the single-port 32 KW × 32-bit on-chip RAM between two requesters (Nios data master and a DMA/peripheral master). It grants at most one access per cycle to the RAM port, routes read data back to the owner with a fixed 1-cycle latency, and quiesces the RAM while `reset_req` is high. It sits between the interconnect and the on-chip memory, driving that memory's `address`, `byteenable`, `chipselect`, `write`, `writedata` and `clken` inputs and consuming its `readdata`.

---
 rtl/nios_qsys_onchip_mem_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_nios_qsys_onchip_mem_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/nios_qsys_onchip_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : nios_qsys_onchip_mem_arbiter
//  Purpose  : Two-port Avalon-MM arbiter in front of a single-port on-chip
//             RAM (Nios data master on m0, DMA/peripheral master on m1).
//             At most one access per cycle reaches the RAM. Read data comes
//             back to its owner one cycle after the grant. While reset_req
//             is high the RAM is quiesced (no grants, chipselect/clken low).
//  Ports    : clk, reset_n (async, active low), reset_req
//             m0_* / m1_* : Avalon-MM slave side (read, write, address,
//                           byteenable, writedata, waitrequest, readdata,
//                           readdatavalid)
//             mem_*       : RAM side (address, byteenable, writedata,
//                           chipselect, write, clken, readdata)
//  Config   : ONCHIP_ARB_ROUND_ROBIN_EN defined -> round-robin on ties,
//             undefined -> fixed priority, m0 wins every tie.
//  Revision : 1.0 - initial release
// ============================================================================
module nios_qsys_onchip_mem_arbiter #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                reset_req,

    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [ADDR_W-1:0]   m0_address,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    input  logic [DATA_W-1:0]   m0_writedata,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_readdatavalid,

    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [ADDR_W-1:0]   m1_address,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    input  logic [DATA_W-1:0]   m1_writedata,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_readdatavalid,

    output logic [ADDR_W-1:0]   mem_address,
    output logic [DATA_W/8-1:0] mem_byteenable,
    output logic [DATA_W-1:0]   mem_writedata,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic                mem_clken,
    input  logic [DATA_W-1:0]   mem_readdata
);

    typedef enum logic [0:0] {
        ST_RUN     = 1'b0,
        ST_QUIESCE = 1'b1
    } state_e;

    state_e              state_q;
    state_e              state_d;
    logic                quiesce;
    logic                req0;
    logic                req1;
    logic                grant0;
    logic                grant1;
    logic                grant_any;
    logic                rd_pending_q;
    logic                rd_pending_d;
    logic                rd_owner_q;
    logic [DATA_W-1:0]   m0_rdata_q;
    logic [DATA_W-1:0]   m1_rdata_q;

`ifdef ONCHIP_ARB_ROUND_ROBIN_EN
    // 1 = m1 was granted last, 0 = m0 was granted last.
    logic                last_grant_q;
`endif

    assign req0      = m0_read | m0_write;
    assign req1      = m1_read | m1_write;
    assign grant_any = grant0 | grant1;

    // ------------------------------------------------------------------
    // FSM next state and arbitration. reset_req is looked at directly so
    // that the cycle it rises already issues no grant, and the cycle it
    // falls already arbitrates again (the state register only catches up
    // at the following edge).
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        quiesce = 1'b0;
        grant0  = 1'b0;
        grant1  = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (reset_req) begin
                    state_d = ST_QUIESCE;
                    quiesce = 1'b1;
                end
            end
            ST_QUIESCE: begin
                if (reset_req) begin
                    quiesce = 1'b1;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        // reset_n gates the grant so every output shows its reset value
        // as soon as reset is asserted, not only after the next edge.
        if (reset_n && !quiesce) begin
            if (req0 && req1) begin
`ifdef ONCHIP_ARB_ROUND_ROBIN_EN
                grant0 = last_grant_q;
                grant1 = ~last_grant_q;
`else
                grant0 = 1'b1;
`endif
            end else begin
                grant0 = req0;
                grant1 = req1;
            end
        end
    end

    // ------------------------------------------------------------------
    // RAM-side mux and handshake outputs.
    // ------------------------------------------------------------------
    always_comb begin
        mem_address    = '0;
        mem_byteenable = '0;
        mem_writedata  = '0;
        mem_write      = 1'b0;
        if (grant1) begin
            mem_address    = m1_address;
            mem_byteenable = m1_byteenable;
            mem_writedata  = m1_writedata;
            mem_write      = m1_write;
        end else if (grant0) begin
            mem_address    = m0_address;
            mem_byteenable = m0_byteenable;
            mem_writedata  = m0_writedata;
            mem_write      = m0_write;
        end
    end

    assign mem_chipselect = grant_any;
    assign mem_clken      = reset_n & ~quiesce;
    assign m0_waitrequest = ~grant0;
    assign m1_waitrequest = ~grant1;

    // A write wins over a simultaneous read, so only a pure read returns data.
    assign rd_pending_d = grant_any & ~mem_write;

    // ------------------------------------------------------------------
    // Read return: the RAM output is unregistered, so the owner sees
    // mem_readdata directly in the return cycle; the hold registers keep
    // the last returned word for the rest of the time.
    // ------------------------------------------------------------------
    assign m0_readdatavalid = rd_pending_q & ~rd_owner_q;
    assign m1_readdatavalid = rd_pending_q &  rd_owner_q;
    assign m0_readdata      = m0_readdatavalid ? mem_readdata : m0_rdata_q;
    assign m1_readdata      = m1_readdatavalid ? mem_readdata : m1_rdata_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_RUN;
            rd_pending_q <= 1'b0;
            rd_owner_q   <= 1'b0;
            m0_rdata_q   <= '0;
            m1_rdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            rd_pending_q <= rd_pending_d;
            if (grant_any) begin
                rd_owner_q <= grant1;
            end
            if (m0_readdatavalid) begin
                m0_rdata_q <= mem_readdata;
            end
            if (m1_readdatavalid) begin
                m1_rdata_q <= mem_readdata;
            end
        end
    end

`ifdef ONCHIP_ARB_ROUND_ROBIN_EN
    // Starts at m1 so that m0 wins the first tie after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant_q <= 1'b1;
        end else if (grant_any) begin
            last_grant_q <= grant1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_nios_qsys_onchip_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_nios_qsys_onchip_mem_arbiter
//  Purpose  : Self-checking bench for nios_qsys_onchip_mem_arbiter with a
//             behavioural 32 KW x 32 on-chip RAM (registered read port).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_nios_qsys_onchip_mem_arbiter;

`ifdef ONCHIP_ARB_ROUND_ROBIN_EN
    localparam logic RR = 1'b1;
`else
    localparam logic RR = 1'b0;
`endif

    localparam logic [1:0]  NO = 2'b00;
    localparam logic [1:0]  RD = 2'b10;
    localparam logic [1:0]  WR = 2'b01;
    localparam logic [1:0]  RW = 2'b11;
    localparam logic        L  = 1'b0;
    localparam logic        H  = 1'b1;
    localparam logic [14:0] Z15 = 15'h0000;
    localparam logic [14:0] A10 = 15'h0010;
    localparam logic [14:0] A01 = 15'h0001;
    localparam logic [14:0] ATP = 15'h7FFF;
    localparam logic [3:0]  Z4  = 4'h0;
    localparam logic [3:0]  F4  = 4'hF;
    localparam logic [31:0] Z32 = 32'h0000_0000;
    localparam logic [31:0] DF  = 32'hDEAD_BEEF;
    localparam logic [31:0] DB  = 32'h1122_3344;
    localparam logic [31:0] DG  = 32'h0022_0000;
    localparam logic [31:0] DA  = 32'hA5A5_A5A5;

    logic        clk;
    logic        reset_n;
    logic        reset_req;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [14:0] m0_address, m1_address;
    logic [3:0]  m0_byteenable, m1_byteenable;
    logic [31:0] m0_writedata, m1_writedata;
    logic        m0_waitrequest, m1_waitrequest;
    logic [31:0] m0_readdata, m1_readdata;
    logic        m0_readdatavalid, m1_readdatavalid;
    logic [14:0] mem_address;
    logic [3:0]  mem_byteenable;
    logic [31:0] mem_writedata;
    logic        mem_chipselect, mem_write, mem_clken;
    logic [31:0] mem_readdata;

    nios_qsys_onchip_mem_arbiter #(.ADDR_W(15), .DATA_W(32)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .reset_req        (reset_req),
        .m0_read          (m0_read),
        .m0_write         (m0_write),
        .m0_address       (m0_address),
        .m0_byteenable    (m0_byteenable),
        .m0_writedata     (m0_writedata),
        .m0_waitrequest   (m0_waitrequest),
        .m0_readdata      (m0_readdata),
        .m0_readdatavalid (m0_readdatavalid),
        .m1_read          (m1_read),
        .m1_write         (m1_write),
        .m1_address       (m1_address),
        .m1_byteenable    (m1_byteenable),
        .m1_writedata     (m1_writedata),
        .m1_waitrequest   (m1_waitrequest),
        .m1_readdata      (m1_readdata),
        .m1_readdatavalid (m1_readdatavalid),
        .mem_address      (mem_address),
        .mem_byteenable   (mem_byteenable),
        .mem_writedata    (mem_writedata),
        .mem_chipselect   (mem_chipselect),
        .mem_write        (mem_write),
        .mem_clken        (mem_clken),
        .mem_readdata     (mem_readdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM: address registered when clken, data valid next cycle.
    logic [31:0] ram [0:32767];
    logic [31:0] ram_q;
    assign mem_readdata = ram_q;

    always @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < 32768; i++) ram[i] <= 32'h0;
            ram[16] <= DF;
            ram_q   <= 32'h0;
        end else if (mem_clken) begin
            if (mem_chipselect && mem_write) begin
                for (int b = 0; b < 4; b++)
                    if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
            end
            ram_q <= ram[mem_address];
        end
    end

    typedef struct {
        logic [1:0]  op0; logic [14:0] a0; logic [3:0] be0; logic [31:0] wd0;
        logic [1:0]  op1; logic [14:0] a1; logic [3:0] be1; logic [31:0] wd1;
        logic        rq;
        logic        w0, w1, cs, we, ck;
        logic [14:0] ea; logic [3:0] ebe; logic [31:0] ewd;
        logic        v0, v1;
        logic [31:0] d0, d1;
    } vec_t;

    localparam int NV = 19;
    vec_t vt [NV];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step=%0d actual=%h expected=%h", nm, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        {m0_read, m0_write} = v.op0;
        m0_address = v.a0; m0_byteenable = v.be0; m0_writedata = v.wd0;
        {m1_read, m1_write} = v.op1;
        m1_address = v.a1; m1_byteenable = v.be1; m1_writedata = v.wd1;
        reset_req = v.rq;
    endtask

    task automatic check_vec(input int i, input vec_t v);
        chk("m0_waitrequest",   i, {31'h0, m0_waitrequest},   {31'h0, v.w0});
        chk("m1_waitrequest",   i, {31'h0, m1_waitrequest},   {31'h0, v.w1});
        chk("mem_chipselect",   i, {31'h0, mem_chipselect},   {31'h0, v.cs});
        chk("mem_write",        i, {31'h0, mem_write},        {31'h0, v.we});
        chk("mem_clken",        i, {31'h0, mem_clken},        {31'h0, v.ck});
        chk("mem_address",      i, {17'h0, mem_address},      {17'h0, v.ea});
        chk("mem_byteenable",   i, {28'h0, mem_byteenable},   {28'h0, v.ebe});
        chk("mem_writedata",    i, mem_writedata,             v.ewd);
        chk("m0_readdatavalid", i, {31'h0, m0_readdatavalid}, {31'h0, v.v0});
        chk("m1_readdatavalid", i, {31'h0, m1_readdatavalid}, {31'h0, v.v1});
        chk("m0_readdata",      i, m0_readdata,               v.d0);
        chk("m1_readdata",      i, m1_readdata,               v.d1);
    endtask

    initial begin
        //         op0 a0   be0 wd0   op1 a1   be1 wd1   rq  w0   w1   cs we ck  ea                 ebe wd    v0   v1   d0  d1
        vt[0]  = '{NO, Z15, Z4, Z32,  NO, Z15, Z4, Z32,  L,  H,   H,   L, L, H,  Z15,               Z4, Z32,  L,   L,   Z32, Z32};
        vt[1]  = '{RD, A10, F4, Z32,  NO, Z15, Z4, Z32,  L,  L,   H,   H, L, H,  A10,               F4, Z32,  L,   L,   Z32, Z32};
        vt[2]  = '{NO, Z15, Z4, Z32,  NO, Z15, Z4, Z32,  L,  H,   H,   L, L, H,  Z15,               Z4, Z32,  H,   L,   DF,  Z32};
        vt[3]  = '{NO, Z15, Z4, Z32,  WR, ATP, 4'h4, DB, L,  H,   L,   H, H, H,  ATP,               4'h4, DB, L,   L,   DF,  Z32};
        vt[4]  = '{NO, Z15, Z4, Z32,  RD, ATP, F4, Z32,  L,  H,   L,   H, L, H,  ATP,               F4, Z32,  L,   L,   DF,  Z32};
        vt[5]  = '{RD, A10, F4, Z32,  RD, ATP, F4, Z32,  L,  L,   H,   H, L, H,  A10,               F4, Z32,  L,   H,   DF,  DG};
        vt[6]  = '{RD, A10, F4, Z32,  RD, ATP, F4, Z32,  L,  RR,  !RR, H, L, H,  RR ? ATP : A10,    F4, Z32,  H,   L,   DF,  DG};
        vt[7]  = '{RD, A10, F4, Z32,  RD, ATP, F4, Z32,  L,  L,   H,   H, L, H,  A10,               F4, Z32,  !RR, RR,  DF,  DG};
        vt[8]  = '{RD, A10, F4, Z32,  RD, ATP, F4, Z32,  L,  RR,  !RR, H, L, H,  RR ? ATP : A10,    F4, Z32,  H,   L,   DF,  DG};
        vt[9]  = '{NO, Z15, Z4, Z32,  NO, Z15, Z4, Z32,  L,  H,   H,   L, L, H,  Z15,               Z4, Z32,  !RR, RR,  DF,  DG};
        vt[10] = '{RW, A01, F4, DA,   NO, Z15, Z4, Z32,  L,  L,   H,   H, H, H,  A01,               F4, DA,   L,   L,   DF,  DG};
        vt[11] = '{NO, Z15, Z4, Z32,  NO, Z15, Z4, Z32,  L,  H,   H,   L, L, H,  Z15,               Z4, Z32,  L,   L,   DF,  DG};
        vt[12] = '{RD, A01, F4, Z32,  NO, Z15, Z4, Z32,  L,  L,   H,   H, L, H,  A01,               F4, Z32,  L,   L,   DF,  DG};
        vt[13] = '{NO, Z15, Z4, Z32,  NO, Z15, Z4, Z32,  L,  H,   H,   L, L, H,  Z15,               Z4, Z32,  H,   L,   DA,  DG};
        // Quiesce: read granted, then reset_req rises while m1 requests.
        vt[14] = '{RD, A10, F4, Z32,  NO, Z15, Z4, Z32,  L,  L,   H,   H, L, H,  A10,               F4, Z32,  L,   L,   DA,  DG};
        vt[15] = '{NO, Z15, Z4, Z32,  RD, ATP, F4, Z32,  H,  H,   H,   L, L, L,  Z15,               Z4, Z32,  H,   L,   DF,  DG};
        vt[16] = '{NO, Z15, Z4, Z32,  RD, ATP, F4, Z32,  H,  H,   H,   L, L, L,  Z15,               Z4, Z32,  L,   L,   DF,  DG};
        vt[17] = '{NO, Z15, Z4, Z32,  RD, ATP, F4, Z32,  L,  H,   L,   H, L, H,  ATP,               F4, Z32,  L,   L,   DF,  DG};
        vt[18] = '{NO, Z15, Z4, Z32,  NO, Z15, Z4, Z32,  L,  H,   H,   L, L, H,  Z15,               Z4, Z32,  L,   H,   DF,  DG};

        // Reset with requests active: outputs must show reset values.
        reset_n = 1'b0;
        drive(vt[0]);
        m0_read  = 1'b1;
        m1_write = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        chk("rst m0_waitrequest",   -1, {31'h0, m0_waitrequest},   32'h1);
        chk("rst m1_waitrequest",   -1, {31'h0, m1_waitrequest},   32'h1);
        chk("rst mem_chipselect",   -1, {31'h0, mem_chipselect},   32'h0);
        chk("rst mem_write",        -1, {31'h0, mem_write},        32'h0);
        chk("rst mem_clken",        -1, {31'h0, mem_clken},        32'h0);
        chk("rst m0_readdatavalid", -1, {31'h0, m0_readdatavalid}, 32'h0);
        chk("rst m1_readdatavalid", -1, {31'h0, m1_readdatavalid}, 32'h0);
        chk("rst m0_readdata",      -1, m0_readdata,               32'h0);
        chk("rst m1_readdata",      -1, m1_readdata,               32'h0);
        drive(vt[0]);
        reset_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            drive(vt[i]);
            #2;
            check_vec(i, vt[i]);
            @(posedge clk); #1;
        end

        // Asynchronous reset in the cycle after a granted read.
        m0_read = 1'b1; m0_address = A10; m0_byteenable = F4;
        #2;
        chk("mid m0_waitrequest", 100, {31'h0, m0_waitrequest}, 32'h0);
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        chk("mid m0_readdatavalid", 101, {31'h0, m0_readdatavalid}, 32'h0);
        chk("mid m0_readdata",      101, m0_readdata,               32'h0);
        chk("mid m1_readdata",      101, m1_readdata,               32'h0);
        chk("mid m0_waitrequest",   101, {31'h0, m0_waitrequest},   32'h1);
        chk("mid mem_chipselect",   101, {31'h0, mem_chipselect},   32'h0);
        chk("mid mem_clken",        101, {31'h0, mem_clken},        32'h0);
        chk("mid mem_write",        101, {31'h0, mem_write},        32'h0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        m0_read = 1'b0;
        #2;
        chk("post m0_readdatavalid", 102, {31'h0, m0_readdatavalid}, 32'h0);
        chk("post m0_readdata",      102, m0_readdata,               32'h0);
        chk("post mem_clken",        102, {31'h0, mem_clken},        32'h1);
        @(posedge clk); #3;
        chk("post m0_readdatavalid", 103, {31'h0, m0_readdatavalid}, 32'h0);
        chk("post m1_readdatavalid", 103, {31'h0, m1_readdatavalid}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
